// File: rtl/morph_filter_3x3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : morph_pkg
// Purpose  : Shared types and helpers for the 3x3 morphology filter.
// Revision : 1.0 - initial release
// ============================================================================
package morph_pkg;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'd0,
        MODE_ERODE  = 2'd1,
        MODE_DILATE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    // Helpers work on a wide container; callers zero-extend and truncate back.
    localparam int c_PIX_MAX_W = 32;
    typedef logic [c_PIX_MAX_W-1:0] pix_t;

    function automatic pix_t neutral_val(input mode_e mode);
        return (mode == MODE_ERODE) ? '1 : '0;
    endfunction

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        pix_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
        pix_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/morph_filter_3x3_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : morph_line_buffer
// Purpose  : Clock-enabled DEPTH-word delay line (circular RAM + pointer).
// Revision : 1.0 - initial release
// ============================================================================
module morph_line_buffer #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 640
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    localparam int              c_PW       = $clog2(DEPTH);
    localparam logic [c_PW-1:0] c_PTR_LAST = c_PW'(DEPTH - 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]   r_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == c_PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_data;
        end
    end

    // Read-before-write: the slot about to be overwritten holds the word from DEPTH advances ago.
    assign o_data = r_mem[r_ptr];

endmodule
`default_nettype wire

// File: rtl/morph_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module   : morph_filter_3x3
// Purpose  : Streaming 3x3 greyscale erode/dilate/pass/fill with border
//            masking and end-of-frame flush. MORPH_CROSS_EN adds iSHAPE.
// Revision : 1.0 - initial release
// ============================================================================
module morph_filter_3x3
    import morph_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [DATA_W-1:0] iDATA,
    input  logic [1:0]        iMODE,
`ifdef MORPH_CROSS_EN
    input  logic              iSHAPE,
`endif
    output logic              oREADY,
    output logic              oDVAL,
    output logic              oSOF,
    output logic [DATA_W-1:0] oDATA
);

    localparam int              c_CW           = $clog2(IMG_W);
    localparam int              c_RW           = $clog2(IMG_H);
    localparam int              c_FW           = $clog2(IMG_W + 1);
    localparam logic [c_CW-1:0] c_COL_LAST     = c_CW'(IMG_W - 1);
    localparam logic [c_CW-1:0] c_COL_ONE      = c_CW'(1);
    localparam logic [c_RW-1:0] c_ROW_LAST     = c_RW'(IMG_H - 1);
    localparam logic [c_RW-1:0] c_ROW_ONE      = c_RW'(1);
    localparam logic [c_FW-1:0] c_FLUSH_LAST   = c_FW'(IMG_W);

    state_e            r_state, w_state_nxt;
    mode_e             r_mode;
    logic [c_CW-1:0]   r_col, r_ncol, r_ccol;
    logic [c_RW-1:0]   r_row, r_nrow, r_crow;
    logic [c_FW-1:0]   r_fcnt;
    logic              r_win_vld;
    logic [DATA_W-1:0] r_win [3][3];
    logic [DATA_W-1:0] w_lb0, w_lb1, w_result;
    logic              w_acc, w_sof_acc, w_px_acc, w_resync, w_last_px;
    logic              w_adv, w_produce, w_plus;

    // ---------------- FSM ----------------
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_sof_acc) w_state_nxt = ST_STREAM;
            ST_STREAM: if (w_last_px) w_state_nxt = ST_FLUSH;
            ST_FLUSH:  if (r_fcnt == c_FLUSH_LAST) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        oREADY    = (r_state != ST_FLUSH);
        w_acc     = iDVAL & oREADY;
        w_sof_acc = w_acc & iSOF;
        w_resync  = w_sof_acc & (r_state == ST_STREAM);
        w_px_acc  = w_acc & ~iSOF & (r_state == ST_STREAM);
        w_last_px = w_px_acc & (r_row == c_ROW_LAST) & (r_col == c_COL_LAST);
        w_adv     = w_sof_acc | w_px_acc | (r_state == ST_FLUSH);
        // Sample index >= IMG_W+1 means a window centre is complete.
        w_produce = (r_state == ST_FLUSH) |
                    (w_px_acc & (r_row != '0) & ~((r_row == c_ROW_ONE) & (r_col == '0)));
    end

    // ---------------- counters and mode latch ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_col     <= '0;
            r_row     <= '0;
            r_ncol    <= '0;
            r_nrow    <= '0;
            r_ccol    <= '0;
            r_crow    <= '0;
            r_fcnt    <= '0;
            r_win_vld <= 1'b0;
            r_mode    <= MODE_PASS;
        end else begin
            if (w_sof_acc) begin
                r_col  <= c_COL_ONE;
                r_row  <= '0;
                r_mode <= mode_e'(iMODE);
            end else if (w_px_acc) begin
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            r_fcnt <= (r_state == ST_FLUSH) ? r_fcnt + 1'b1 : '0;
            if (w_sof_acc) begin
                r_ncol <= '0;
                r_nrow <= '0;
            end else if (w_produce) begin
                r_ccol <= r_ncol;
                r_crow <= r_nrow;
                if (r_ncol == c_COL_LAST) begin
                    r_ncol <= '0;
                    r_nrow <= (r_nrow == c_ROW_LAST) ? '0 : r_nrow + 1'b1;
                end else begin
                    r_ncol <= r_ncol + 1'b1;
                end
            end
            r_win_vld <= w_produce;
        end
    end

`ifdef MORPH_CROSS_EN
    logic r_shape;
    always_ff @(posedge CLK) begin
        if (RST)            r_shape <= 1'b0;
        else if (w_sof_acc) r_shape <= iSHAPE;
    end
    assign w_plus = r_shape;
`else
    assign w_plus = 1'b0;
`endif

    // ---------------- line buffers and window ----------------
    morph_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
        .clk(CLK), .rst(RST), .i_en(w_adv), .i_data(iDATA), .o_data(w_lb0)
    );
    morph_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
        .clk(CLK), .rst(RST), .i_en(w_adv), .i_data(w_lb0), .o_data(w_lb1)
    );

    always_ff @(posedge CLK) begin
        if (w_adv) begin
            for (int i = 0; i < 3; i++) begin
                r_win[i][0] <= r_win[i][1];
                r_win[i][1] <= r_win[i][2];
            end
            r_win[0][2] <= w_lb1;
            r_win[1][2] <= w_lb0;
            r_win[2][2] <= iDATA;
        end
    end

    // Out-of-frame taps (including stale line-buffer words) become neutral.
    always_comb begin
        pix_t w_nb [3][3];
        pix_t w_rmin [3];
        pix_t w_rmax [3];
        logic w_mask;
        w_result = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                w_mask = ((i == 0) && (r_crow == '0)) || ((i == 2) && (r_crow == c_ROW_LAST)) ||
                         ((j == 0) && (r_ccol == '0)) || ((j == 2) && (r_ccol == c_COL_LAST)) ||
                         (w_plus && (i != 1) && (j != 1));
                w_nb[i][j] = w_mask ? neutral_val(r_mode) : pix_t'(r_win[i][j]);
            end
            w_rmin[i] = min3(w_nb[i][0], w_nb[i][1], w_nb[i][2]);
            w_rmax[i] = max3(w_nb[i][0], w_nb[i][1], w_nb[i][2]);
        end
        case (r_mode)
            MODE_PASS:   w_result = r_win[1][1];
            MODE_ERODE:  w_result = DATA_W'(min3(w_rmin[0], w_rmin[1], w_rmin[2]));
            MODE_DILATE: w_result = DATA_W'(max3(w_rmax[0], w_rmax[1], w_rmax[2]));
            default:     w_result = '1;
        endcase
    end

    // A resync drops the last pending centre of the abandoned frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            oDVAL <= 1'b0;
            oSOF  <= 1'b0;
            oDATA <= '0;
        end else begin
            oDVAL <= r_win_vld & ~w_resync;
            oSOF  <= r_win_vld & ~w_resync & (r_crow == '0) & (r_ccol == '0);
            if (r_win_vld) oDATA <= w_result;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_morph_filter_3x3.sv
`default_nettype none
// ============================================================================
// Module   : tb_morph_filter_3x3
// Purpose  : Directed self-checking bench for morph_filter_3x3 (8x4 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_morph_filter_3x3;

    localparam int c_PAT_RAMP = 0, c_PAT_HOLE = 1, c_PAT_DOT = 2, c_PAT_C900 = 3, c_PAT_SEVEN = 4;
    localparam int c_EXP_RAMP = 0, c_EXP_ERODE = 1, c_EXP_DOT = 2, c_EXP_DILRAMP = 3,
                   c_EXP_FILL = 4, c_EXP_SEVEN = 5;

    logic       clk, rst, iDVAL, iSOF, oREADY, oDVAL, oSOF;
    logic [9:0] iDATA, oDATA;
    logic [1:0] iMODE;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct { int data; bit sof; int cyc; } out_t;
    out_t oq[$];

    typedef struct { logic [1:0] m0; logic [1:0] m1; int pat; bit gaps; int expk; } vec_t;
    vec_t tbl [6];

    morph_filter_3x3 #(.DATA_W(10), .IMG_W(8), .IMG_H(4)) dut (
        .CLK(clk), .RST(rst), .iDVAL(iDVAL), .iSOF(iSOF), .iDATA(iDATA), .iMODE(iMODE),
`ifdef MORPH_CROSS_EN
        .iSHAPE(1'b0),
`endif
        .oREADY(oREADY), .oDVAL(oDVAL), .oSOF(oSOF), .oDATA(oDATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (oDVAL) oq.push_back('{int'(oDATA), oSOF, cyc});

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pat_px(input int pat, input int p);
        int r, c;
        r = p / 8;
        c = p % 8;
        case (pat)
            c_PAT_RAMP: return p;
            c_PAT_HOLE: return (r == 2 && c == 4) ? 0 : 1023;
            c_PAT_DOT:  return (r == 0 && c == 0) ? 500 : 0;
            c_PAT_C900: return 900;
            default:    return 7;
        endcase
    endfunction

    function automatic int exp_px(input int k, input int r, input int c);
        case (k)
            c_EXP_RAMP:    return r * 8 + c;
            c_EXP_ERODE:   return (r >= 1 && c >= 3 && c <= 5) ? 0 : 1023;
            c_EXP_DOT:     return (r <= 1 && c <= 1) ? 500 : 0;
            c_EXP_DILRAMP: return ((r + 1 > 3) ? 3 : r + 1) * 8 + ((c + 1 > 7) ? 7 : c + 1);
            c_EXP_FILL:    return 1023;
            c_EXP_SEVEN:   return 7;
            default:       return -1;
        endcase
    endfunction

    // Drives npix pixels (SOF on the first); reports the edges that accept pixel 0 and pixel 9.
    task automatic drive(input logic [1:0] m0, input logic [1:0] m1, input int pat, input bit gaps,
                         input int npix, output int acc9, output int acc0);
        int p = 0;
        int guard = 0;
        acc9 = -1;
        acc0 = -1;
        while (p < npix && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                iDVAL = 1'b0;
                iSOF  = 1'b0;
            end else begin
                iDVAL = 1'b1;
                iSOF  = (p == 0);
                iDATA = 10'(pat_px(pat, p));
                iMODE = (p >= 6) ? m1 : m0;
                if (oREADY) begin
                    if (p == 0) acc0 = cyc + 1;
                    if (p == 9) acc9 = cyc + 1;
                    p++;
                end
            end
        end
        if (p < npix) chk("drive_timeout", p, npix);
    endtask

    task automatic finish_frame(input string tag);
        int nlow = 0;
        @(negedge clk);
        iDVAL = 1'b0;
        iSOF  = 1'b0;
        while (!oREADY && nlow < 50) begin
            nlow++;
            @(negedge clk);
        end
        chk({tag, "_ready_low"}, nlow, 9);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int start, input int expk, input int acc9);
        int n = 0;
        int first = -1;
        foreach (oq[i]) begin
            if (oq[i].cyc > start) begin
                if (n < 32) begin
                    chk($sformatf("%s_px%0d", tag, n), oq[i].data, exp_px(expk, n / 8, n % 8));
                    chk($sformatf("%s_sof%0d", tag, n), int'(oq[i].sof), (n == 0) ? 1 : 0);
                end
                if (first < 0) first = oq[i].cyc;
                n++;
            end
        end
        chk({tag, "_count"}, n, 32);
        chk({tag, "_latency"}, first, acc9 + 1);
    endtask

    function automatic int outs_after(input int start);
        int n = 0;
        foreach (oq[i]) if (oq[i].cyc > start) n++;
        return n;
    endfunction

    initial begin
        int a9, a0, s;
        tbl[0] = '{2'd0, 2'd0, c_PAT_RAMP, 1'b0, c_EXP_RAMP};
        tbl[1] = '{2'd1, 2'd1, c_PAT_HOLE, 1'b0, c_EXP_ERODE};
        tbl[2] = '{2'd2, 2'd2, c_PAT_DOT,  1'b0, c_EXP_DOT};
        tbl[3] = '{2'd0, 2'd2, c_PAT_RAMP, 1'b1, c_EXP_RAMP};
        tbl[4] = '{2'd2, 2'd2, c_PAT_RAMP, 1'b0, c_EXP_DILRAMP};
        tbl[5] = '{2'd3, 2'd3, c_PAT_RAMP, 1'b0, c_EXP_FILL};

        // Reset with valid input held high, then a pixel without SOF.
        rst = 1'b1; iDVAL = 1'b1; iSOF = 1'b0; iDATA = 10'd5; iMODE = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_odval", int'(oDVAL), 0);
        chk("rst_osof", int'(oSOF), 0);
        chk("rst_odata", int'(oDATA), 0);
        chk("rst_oready", int'(oREADY), 1);
        rst = 1'b0;
        s = cyc;
        @(negedge clk);
        iDVAL = 1'b0;
        repeat (15) @(negedge clk);
        chk("nosof_outputs", outs_after(s), 0);
        chk("nosof_oready", int'(oREADY), 1);

        for (int v = 0; v < 6; v++) begin
            drive(tbl[v].m0, tbl[v].m1, tbl[v].pat, tbl[v].gaps, 32, a9, a0);
            finish_frame($sformatf("vec%0d", v));
            check_frame($sformatf("vec%0d", v), a0 - 1, tbl[v].expk, a9);
        end

        // Resync: 13-pixel partial frame, then a full constant frame starting with SOF.
        drive(2'd2, 2'd2, c_PAT_C900, 1'b0, 13, a9, a0);
        drive(2'd2, 2'd2, c_PAT_SEVEN, 1'b0, 32, a9, a0);
        finish_frame("resync");
        check_frame("resync", a0 - 1, c_EXP_SEVEN, a9);

        // Reset in the middle of a frame: nothing may emerge afterwards.
        drive(2'd0, 2'd0, c_PAT_RAMP, 1'b0, 20, a9, a0);
        @(negedge clk);
        rst = 1'b1;
        iDVAL = 1'b0;
        iSOF = 1'b0;
        @(negedge clk);
        chk("midrst_odval", int'(oDVAL), 0);
        chk("midrst_odata", int'(oDATA), 0);
        chk("midrst_oready", int'(oREADY), 1);
        rst = 1'b0;
        s = cyc;
        repeat (20) @(negedge clk);
        chk("midrst_outputs", outs_after(s), 0);

        // Recovery frame after the mid-frame reset.
        drive(2'd0, 2'd0, c_PAT_RAMP, 1'b0, 32, a9, a0);
        finish_frame("recover");
        check_frame("recover", a0 - 1, c_EXP_RAMP, a9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
